trap_csr_unit: RTL and testbench

//  Consumes the control decoder's exception/system outputs (INT_Signal, SCAUSE, MRET, CSRRS) at EX.

---
 rtl/trap_csr_unit.sv | 159 +++++++++++++++
 tb/tb_trap_csr_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/trap_csr_unit.sv
// Machine-mode trap/CSR unit: holds mstatus/mtvec/mepc/mcause and sequences trap entry
// and MRET return as a one-cycle redirect followed by a drain window of flushed EX slots.
module trap_csr_unit #(
  parameter logic [31:0] MTVEC_RESET  = 32'h0000_0100,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_int_i,
  input  logic [7:0]  ex_scause_i,
  input  logic        ex_mret_i,
  input  logic        ex_csrrs_i,
  input  logic [11:0] ex_csr_addr_i,
  input  logic [4:0]  ex_rs1_idx_i,
  input  logic [31:0] ex_rs1_data_i,
  output logic [31:0] csr_rdata_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {StIdle, StRedir, StDrain} state_e;

  localparam logic [11:0] AddrMstatus = 12'h300;
  localparam logic [11:0] AddrMtvec   = 12'h305;
  localparam logic [11:0] AddrMepc    = 12'h341;
  localparam logic [11:0] AddrMcause  = 12'h342;
  localparam logic [3:0]  DrainLoad   = 4'(DRAIN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rpc_q, rpc_d;

  logic        accept;
  logic        take_trap;
  logic        take_mret;
  logic        take_csr;
  logic        csr_wr;
  logic [31:0] csr_old;
  logic [31:0] mstatus_view;

  assign accept    = (state_q == StIdle) && ex_valid_i;
  assign take_trap = accept && ex_int_i;
  assign take_mret = accept && !ex_int_i && ex_mret_i;
  assign take_csr  = accept && !ex_int_i && !ex_mret_i && ex_csrrs_i;
  assign csr_wr    = take_csr && (ex_rs1_idx_i != 5'd0);

  // Only MIE (bit 3) and MPIE (bit 7) exist; all other mstatus bits read as zero.
  assign mstatus_view = {24'h0, mpie_q, 3'b000, mie_q, 3'b000};

  // CSR read mux; unknown addresses read zero.
  always_comb begin
    csr_old = 32'h0;
    unique case (ex_csr_addr_i)
      AddrMstatus: csr_old = mstatus_view;
      AddrMtvec:   csr_old = mtvec_q;
      AddrMepc:    csr_old = mepc_q;
      AddrMcause:  csr_old = mcause_q;
      default:     csr_old = 32'h0;
    endcase
  end

  // CSR next-state: trap entry, MRET return and CSRRS set-bits.
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    rdata_d  = rdata_q;
    rpc_d    = rpc_q;
    if (take_trap) begin
      mepc_d   = ex_pc_i;
      mcause_d = {24'h0, ex_scause_i};
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      rpc_d    = {mtvec_q[31:2], 2'b00};
    end else if (take_mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
      rpc_d  = mepc_q;
    end else if (take_csr) begin
      rdata_d = csr_old;
      if (csr_wr) begin
        unique case (ex_csr_addr_i)
          AddrMstatus: begin
            mie_d  = mie_q | ex_rs1_data_i[3];
            mpie_d = mpie_q | ex_rs1_data_i[7];
          end
          AddrMtvec:  mtvec_d  = mtvec_q | ex_rs1_data_i;
          AddrMepc:   mepc_d   = mepc_q | ex_rs1_data_i;
          AddrMcause: mcause_d = mcause_q | ex_rs1_data_i;
          default: ;
        endcase
      end
    end
  end

  // FSM next-state: redirect for one cycle, then drain for DRAIN_CYCLES cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (take_trap || take_mret) state_d = StRedir;
      end
      StRedir: begin
        state_d = StDrain;
        cnt_d   = DrainLoad;
      end
      StDrain: begin
        if (cnt_q == 4'd0) state_d = StIdle;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and CSR registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtvec_q  <= MTVEC_RESET;
      mepc_q   <= 32'h0;
      mcause_q <= 32'h0;
      rdata_q  <= 32'h0;
      rpc_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      rdata_q  <= rdata_d;
      rpc_q    <= rpc_d;
    end
  end

  assign csr_rdata_o      = rdata_q;
  assign redirect_valid_o = (state_q == StRedir);
  assign redirect_pc_o    = rpc_q;
  assign flush_o          = (state_q != StIdle);
  assign busy_o           = (state_q != StIdle);

endmodule

// File: tb/tb_trap_csr_unit.sv
// Bench for trap_csr_unit: directed scenarios plus randomized traffic against a
// behavioural model that tracks the lockout as a simple remaining-cycle count.
module tb_trap_csr_unit;

  localparam logic [31:0] MtvecRst = 32'h0000_0100;
  localparam int          Drain    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_int;
  logic [7:0]  ex_scause;
  logic        ex_mret;
  logic        ex_csrrs;
  logic [11:0] ex_csr_addr;
  logic [4:0]  ex_rs1_idx;
  logic [31:0] ex_rs1_data;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        busy;

  trap_csr_unit #(.MTVEC_RESET(MtvecRst), .DRAIN_CYCLES(Drain)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ex_valid_i      (ex_valid),
    .ex_pc_i         (ex_pc),
    .ex_int_i        (ex_int),
    .ex_scause_i     (ex_scause),
    .ex_mret_i       (ex_mret),
    .ex_csrrs_i      (ex_csrrs),
    .ex_csr_addr_i   (ex_csr_addr),
    .ex_rs1_idx_i    (ex_rs1_idx),
    .ex_rs1_data_i   (ex_rs1_data),
    .csr_rdata_o     (csr_rdata),
    .redirect_valid_o(redirect_valid),
    .redirect_pc_o   (redirect_pc),
    .flush_o         (flush),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  int          m_lock;
  logic [31:0] m_rpc, m_rdata, m_mstatus, m_mtvec, m_mepc, m_mcause;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'h0;
    endcase
  endfunction

  // Apply the architectural rules for one rising edge using the inputs present at that edge.
  task automatic model_edge();
    logic [31:0] old;
    if (rst) begin
      m_lock = 0; m_rpc = 0; m_rdata = 0;
      m_mstatus = 0; m_mtvec = MtvecRst; m_mepc = 0; m_mcause = 0;
    end else if (m_lock > 0) begin
      m_lock--;
    end else if (ex_valid) begin
      if (ex_int) begin
        m_mepc    = ex_pc;
        m_mcause  = {24'h0, ex_scause};
        m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
        m_rpc     = m_mtvec & ~32'h3;
        m_lock    = 1 + Drain;
      end else if (ex_mret) begin
        m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
        m_rpc     = m_mepc;
        m_lock    = 1 + Drain;
      end else if (ex_csrrs) begin
        old     = m_read(ex_csr_addr);
        m_rdata = old;
        if (ex_rs1_idx != 0) begin
          case (ex_csr_addr)
            12'h300: m_mstatus = (m_mstatus | ex_rs1_data) & 32'h88;
            12'h305: m_mtvec   = m_mtvec | ex_rs1_data;
            12'h341: m_mepc    = m_mepc | ex_rs1_data;
            12'h342: m_mcause  = m_mcause | ex_rs1_data;
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("csr_rdata", csr_rdata, m_rdata);
    check_eq("redirect_valid", {31'h0, redirect_valid}, {31'h0, m_lock == 1 + Drain});
    check_eq("redirect_pc", redirect_pc, m_rpc);
    check_eq("flush", {31'h0, flush}, {31'h0, m_lock != 0});
    check_eq("busy", {31'h0, busy}, {31'h0, m_lock != 0});
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic it, input logic [7:0] sc,
                       input logic mr, input logic cs, input logic [11:0] a, input logic [4:0] idx,
                       input logic [31:0] d);
    ex_valid = v; ex_pc = pc; ex_int = it; ex_scause = sc; ex_mret = mr;
    ex_csrrs = cs; ex_csr_addr = a; ex_rs1_idx = idx; ex_rs1_data = d;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 8'h0, 1'b0, 1'b0, 12'h0, 5'd0, 32'h0);
  endtask

  task automatic do_csrrs(input logic [11:0] a, input logic [4:0] idx, input logic [31:0] d,
                          input logic [31:0] exp);
    drive(1'b1, 32'h200, 1'b0, 8'h0, 1'b0, 1'b1, a, idx, d);
    step();
    check_eq("csrrs_read", csr_rdata, exp);
    idle();
  endtask

  task automatic do_trap(input logic [31:0] pc, input logic [7:0] sc);
    drive(1'b1, pc, 1'b1, sc, 1'b0, 1'b0, 12'h0, 5'd0, 32'h0);
    step();
    idle();
  endtask

  initial begin
    logic [11:0] addrs [6];
    addrs = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h7C0, 12'h001};
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_flush", {31'h0, flush}, 32'h0);
    check_eq("rst_rpc", redirect_pc, 32'h0);

    // Reset mtvec, then enable MIE.
    do_csrrs(12'h305, 5'd0, 32'h0, 32'h100);
    do_csrrs(12'h300, 5'd1, 32'h8, 32'h0);

    // ecall, followed one cycle later by an illegal instruction that must be ignored.
    do_trap(32'h40, 8'h08);
    check_eq("ecall_rv", {31'h0, redirect_valid}, 32'h1);
    check_eq("ecall_rpc", redirect_pc, 32'h100);
    drive(1'b1, 32'h44, 1'b1, 8'h02, 1'b0, 1'b0, 12'h0, 5'd0, 32'h0);
    step();
    check_eq("nested_rv", {31'h0, redirect_valid}, 32'h0);
    check_eq("nested_flush", {31'h0, flush}, 32'h1);
    idle();
    step();
    step();
    check_eq("drain_done", {31'h0, busy}, 32'h0);
    do_csrrs(12'h342, 5'd0, 32'hFFFF_FFFF, 32'h8);
    do_csrrs(12'h342, 5'd0, 32'h0, 32'h8);
    do_csrrs(12'h341, 5'd0, 32'h0, 32'h40);
    do_csrrs(12'h300, 5'd0, 32'h0, 32'h80);

    // MRET back to mepc; busy for exactly three cycles.
    drive(1'b1, 32'h300, 1'b0, 8'h0, 1'b1, 1'b0, 12'h0, 5'd0, 32'h0);
    step();
    idle();
    check_eq("mret_rpc", redirect_pc, 32'h40);
    check_eq("mret_rv", {31'h0, redirect_valid}, 32'h1);
    step();
    step();
    check_eq("mret_busy3", {31'h0, busy}, 32'h1);
    step();
    check_eq("mret_busy_fall", {31'h0, busy}, 32'h0);
    do_csrrs(12'h300, 5'd0, 32'h0, 32'h88);

    // mtvec set-bits; trap vector aligns low bits away.
    do_csrrs(12'h305, 5'd5, 32'h3, 32'h100);
    do_csrrs(12'h305, 5'd0, 32'h0, 32'h103);
    do_csrrs(12'h7C0, 5'd5, 32'hFF, 32'h0);
    drive(1'b1, 32'h80, 1'b1, 8'h08, 1'b0, 1'b1, 12'h305, 5'd5, 32'hF0);
    step();
    idle();
    check_eq("trap_over_csr_rpc", redirect_pc, 32'h100);
    repeat (Drain + 1) step();
    do_csrrs(12'h305, 5'd0, 32'h0, 32'h103);

    // Reset in the middle of the drain window.
    do_trap(32'h90, 8'h02);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_drain_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_drain_flush", {31'h0, flush}, 32'h0);
    do_csrrs(12'h305, 5'd0, 32'h0, 32'h100);
    do_csrrs(12'h341, 5'd0, 32'h0, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 8), $urandom, ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 1) != 0) ? 8'h08 : 8'h02, ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) < 5), addrs[$urandom_range(0, 5)],
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
